iic_arbiter: RTL and testbench

//   Shares one iic_dri master between NUM_REQ register-table sequencers (ms7200 LUT, ms7210 LUT,

---
 rtl/iic_pkg.sv | 27 ++
 rtl/iic_rr_pick.sv | 36 +++
 rtl/iic_arbiter.sv | 151 +++++++++++++++
 tb/tb_iic_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared definitions for the iic_dri arbiter: FSM encoding, command record, defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package iic_pkg;

   localparam int ADDR_W        = 16;
   localparam int DATA_W        = 8;
   localparam int DEVID_W       = 8;
   localparam int START_TMO_DEF = 1023;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_RUN       = 3'd3,
      ST_DONE      = 3'd4
   } iic_state_e;

   // One latched I2C command as handed to iic_dri.
   typedef struct packed {
      logic               w_r;
      logic [DEVID_W-1:0] device_id;
      logic [ADDR_W-1:0]  addr;
      logic [DATA_W-1:0]  data_in;
   } iic_cmd_t;

endpackage

// File: rtl/iic_rr_pick.sv
// Round-robin picker: first pending index strictly after rr_ptr, wrapping mod NUM_REQ.
// Latency: combinational.
// Backpressure: none; grant_vld is low when nothing is pending.
// Ports: pending (request vector), rr_ptr (last served index), grant_oh (one-hot), grant_vld.
module iic_rr_pick
   import iic_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] pending,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant_oh,
   output logic               grant_vld
);

   localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

   // One extra bit so ptr + k never overflows before the wrap subtraction.
   logic [IDX_W:0] idx;

   always_comb begin
      grant_oh  = '0;
      grant_vld = 1'b0;
      idx       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (idx >= NUM_REQ_W) idx = idx - NUM_REQ_W;
         if (!grant_vld && pending[idx[IDX_W-1:0]]) begin
            grant_oh[idx[IDX_W-1:0]] = 1'b1;
            grant_vld                = 1'b1;
         end
      end
   end

endmodule

// File: rtl/iic_arbiter.sv
// Shares one iic_dri master between NUM_REQ command sequencers, round-robin, one frame at a time.
// Latency: trigger -> m_pluse 3 cycles when idle; at least IDLE+ISSUE between frames.
// Backpressure: req_busy[i] high while i is pending/in flight; a trigger then is dropped and flags proto_err.
// Ports: sys_clk/sys_rst; req_* per-requester command in, req_busy/req_byte_over/req_data_out back;
//        m_* to/from iic_dri; tmo_err (frame never started) and proto_err (retrigger while busy), both sticky.
module iic_arbiter
   import iic_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int START_TMO = START_TMO_DEF
) (
   input  logic                        sys_clk,
   input  logic                        sys_rst,
   input  logic [NUM_REQ-1:0]          req_trig,
   input  logic [NUM_REQ-1:0]          req_w_r,
   input  logic [DEVID_W*NUM_REQ-1:0]  req_device_id,
   input  logic [ADDR_W*NUM_REQ-1:0]   req_addr,
   input  logic [DATA_W*NUM_REQ-1:0]   req_data_in,
   output logic [NUM_REQ-1:0]          req_busy,
   output logic [NUM_REQ-1:0]          req_byte_over,
   output logic [DATA_W-1:0]           req_data_out,
   output logic [DEVID_W-1:0]          m_device_id,
   output logic                        m_pluse,
   output logic                        m_w_r,
   output logic [ADDR_W-1:0]           m_addr,
   output logic [DATA_W-1:0]           m_data_in,
   input  logic                        m_busy,
   input  logic                        m_byte_over,
   input  logic [DATA_W-1:0]           m_data_out,
   output logic                        tmo_err,
   output logic                        proto_err
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TMO_W = $clog2(START_TMO + 1);
   localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(START_TMO);

   iic_state_e          state;
   iic_state_e          state_nxt;
   logic [NUM_REQ-1:0]  pending;
   iic_cmd_t            cmd_q [NUM_REQ];
   iic_cmd_t            m_cmd;
   logic [IDX_W-1:0]    grant;
   logic [IDX_W-1:0]    rr_ptr;
   logic [TMO_W-1:0]    tmo_cnt;
   logic [DATA_W-1:0]   data_q;
   logic [NUM_REQ-1:0]  pick_oh;
   logic                pick_vld;
   logic [IDX_W-1:0]    pick_idx;

   iic_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .pending   (pending),
      .rr_ptr    (rr_ptr),
      .grant_oh  (pick_oh),
      .grant_vld (pick_vld)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (pick_oh[i]) pick_idx = IDX_W'(i);
   end

   // Per-requester capture. A trigger only lands when the slot is free; the
   // DONE-state clear and a same-cycle retrigger of that slot count as a drop.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         pending   <= '0;
         proto_err <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) cmd_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (state == ST_DONE && grant == IDX_W'(i)) pending[i] <= 1'b0;
            if (req_trig[i]) begin
               if (!pending[i]) begin
                  pending[i]           <= 1'b1;
                  cmd_q[i].w_r         <= req_w_r[i];
                  cmd_q[i].device_id   <= req_device_id[i*DEVID_W +: DEVID_W];
                  cmd_q[i].addr        <= req_addr[i*ADDR_W +: ADDR_W];
                  cmd_q[i].data_in     <= req_data_in[i*DATA_W +: DATA_W];
               end else begin
                  proto_err <= 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      req_byte_over = '0;
      req_data_out  = data_q;
      case (state)
         ST_IDLE:      if (pick_vld) state_nxt = ST_ISSUE;
         ST_ISSUE:     state_nxt = ST_WAIT_BUSY;
         ST_WAIT_BUSY: begin
            if (m_busy)                   state_nxt = ST_RUN;
            else if (tmo_cnt == TMO_LIM)  state_nxt = ST_DONE;
         end
         ST_RUN: begin
            if (m_byte_over) begin
               req_byte_over[grant] = 1'b1;
               req_data_out         = m_data_out;
            end
            if (!m_busy) state_nxt = ST_DONE;
         end
         ST_DONE:      state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   // Datapath registers. m_pluse is registered off ISSUE so iic_dri sees a
   // clean single-cycle strobe while the command fields are already stable.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         grant   <= '0;
         rr_ptr  <= IDX_W'(NUM_REQ - 1);
         m_cmd   <= '0;
         m_pluse <= 1'b0;
         tmo_cnt <= '0;
         tmo_err <= 1'b0;
         data_q  <= '0;
      end else begin
         m_pluse <= (state == ST_ISSUE);
         if (state == ST_IDLE && pick_vld) begin
            grant <= pick_idx;
            m_cmd <= cmd_q[pick_idx];
         end
         if (state == ST_ISSUE)          tmo_cnt <= '0;
         else if (state == ST_WAIT_BUSY) tmo_cnt <= tmo_cnt + 1'b1;
         if (state == ST_WAIT_BUSY && !m_busy && tmo_cnt == TMO_LIM) tmo_err <= 1'b1;
         if (state == ST_RUN && m_byte_over) data_q <= m_data_out;
         if (state == ST_DONE) rr_ptr <= grant;
      end
   end

   assign req_busy    = pending;
   assign m_w_r       = m_cmd.w_r;
   assign m_device_id = m_cmd.device_id;
   assign m_addr      = m_cmd.addr;
   assign m_data_in   = m_cmd.data_in;

endmodule

// File: tb/tb_iic_arbiter.sv
// Bench for iic_arbiter with a behavioural iic_dri and a round-robin order model.
// Latency: n/a.
// Backpressure: n/a.
module tb_iic_arbiter;
   localparam int N = 3;
   localparam int T = 100;

   logic              sys_clk, sys_rst;
   logic [N-1:0]      req_trig, req_w_r, req_busy, req_byte_over;
   logic [8*N-1:0]    req_device_id, req_data_in;
   logic [16*N-1:0]   req_addr;
   logic [7:0]        req_data_out, m_device_id, m_data_in, dri_dout;
   logic              m_pluse, m_w_r, m_busy, dri_bo, stray_bo, dri_mute, tmo_err, proto_err;
   logic [15:0]       m_addr;

   int vec = 0;
   int err = 0;
   int cyc = 0;
   int b2b = 0;
   logic prev_pluse = 1'b0;

   logic       c_w    [N];
   logic [7:0] c_dev  [N];
   logic [15:0] c_addr [N];
   logic [7:0] c_data [N];

   typedef struct packed { logic w; logic [7:0] dev; logic [15:0] addr; logic [7:0] data; int cyc; } pl_s;
   typedef struct packed { logic [N-1:0] mask; logic [7:0] data; } bo_s;
   pl_s pl_q[$];
   bo_s bo_q[$];

   iic_arbiter #(.NUM_REQ(N), .START_TMO(T)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .req_trig(req_trig), .req_w_r(req_w_r), .req_device_id(req_device_id),
      .req_addr(req_addr), .req_data_in(req_data_in),
      .req_busy(req_busy), .req_byte_over(req_byte_over), .req_data_out(req_data_out),
      .m_device_id(m_device_id), .m_pluse(m_pluse), .m_w_r(m_w_r), .m_addr(m_addr),
      .m_data_in(m_data_in), .m_busy(m_busy),
      .m_byte_over(dri_bo | stray_bo),
      .m_data_out(stray_bo ? 8'hEE : dri_dout),
      .tmo_err(tmo_err), .proto_err(proto_err)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   always @(posedge sys_clk) cyc <= cyc + 1;

   // iic_dri stand-in: busy 2 cycles after pluse for 40 cycles, byte_over on cycle 30,
   // read data derived from the address so every frame has a known answer.
   int dri_cnt;
   always @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         dri_cnt <= 0; m_busy <= 1'b0; dri_bo <= 1'b0; dri_dout <= 8'h00;
      end else begin
         dri_bo <= 1'b0;
         if (dri_cnt == 0) begin
            if (m_pluse && !dri_mute) dri_cnt <= 1;
         end else begin
            dri_cnt <= dri_cnt + 1;
            if (dri_cnt == 1)  m_busy <= 1'b1;
            if (dri_cnt == 30) begin dri_bo <= 1'b1; dri_dout <= m_addr[7:0] ^ 8'h5A; end
            if (dri_cnt == 41) begin m_busy <= 1'b0; dri_cnt <= 0; end
         end
      end
   end

   always @(negedge sys_clk) begin
      if (m_pluse === 1'b1) begin
         pl_q.push_back('{w: m_w_r, dev: m_device_id, addr: m_addr, data: m_data_in, cyc: cyc});
         if (prev_pluse) b2b++;
      end
      prev_pluse = m_pluse;
      if (req_byte_over != '0) bo_q.push_back('{mask: req_byte_over, data: req_data_out});
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "watchdog");
   end

   // Spec-level round-robin: first requester in the set after the last one served.
   function automatic int rr_next(input logic [N-1:0] set, input int last);
      for (int k = 1; k <= N; k++)
         if (set[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   task automatic do_reset();
      @(negedge sys_clk);
      sys_rst = 1'b1; req_trig = '0; stray_bo = 1'b0; dri_mute = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1 sys_rst = 1'b0;
   endtask

   task automatic fire(input logic [N-1:0] mask, output int acyc);
      @(posedge sys_clk); #1;
      acyc = cyc;
      for (int i = 0; i < N; i++) if (mask[i]) begin
         req_w_r[i] = c_w[i];
         req_device_id[i*8 +: 8] = c_dev[i];
         req_addr[i*16 +: 16]    = c_addr[i];
         req_data_in[i*8 +: 8]   = c_data[i];
      end
      req_trig = mask;
      @(posedge sys_clk); #1;
      req_trig = '0;
      // Scramble the inputs so only latched commands can reach iic_dri.
      req_w_r       = N'($urandom);
      req_device_id = (8*N)'($urandom);
      req_addr      = (16*N)'({$urandom, $urandom});
      req_data_in   = (8*N)'($urandom);
   endtask

   task automatic rand_cmds(input logic [N-1:0] mask);
      for (int i = 0; i < N; i++) if (mask[i]) begin
         c_w[i] = 1'($urandom); c_dev[i] = 8'($urandom);
         c_addr[i] = 16'($urandom); c_data[i] = 8'($urandom);
      end
   endtask

   task automatic wait_pluse(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge sys_clk); #1;
         if (pl_q.size() >= n) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge sys_clk); #1;
         if (req_busy == '0 && !m_busy) begin ok = 1'b1; break; end
      end
      repeat (3) @(negedge sys_clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      vec++; if (req_busy !== '0 || req_byte_over !== '0) begin err++;
         $display("FAIL reset_req: busy=%b byte_over=%b, required 0", req_busy, req_byte_over); end
      vec++; if (m_pluse !== 1'b0 || m_addr !== 16'h0 || m_device_id !== 8'h0 || m_w_r !== 1'b0) begin err++;
         $display("FAIL reset_m: pluse=%b addr=%h dev=%h w_r=%b, required 0", m_pluse, m_addr, m_device_id, m_w_r); end
      vec++; if (tmo_err !== 1'b0 || proto_err !== 1'b0 || req_data_out !== 8'h00) begin err++;
         $display("FAIL reset_err: tmo=%b proto=%b data_out=%h, required 0", tmo_err, proto_err, req_data_out); end
      repeat (2) @(posedge sys_clk);
      #1 sys_rst = 1'b0;
      repeat (4) @(negedge sys_clk);
      vec++; if (req_busy !== '0 || pl_q.size() != 0) begin err++;
         $display("FAIL reset_quiet: busy=%b pluses=%0d, required 0 and 0", req_busy, pl_q.size()); end
   endtask

   task automatic test_single_write();
      int acyc; bit ok;
      pl_q.delete(); bo_q.delete(); b2b = 0;
      c_w[0] = 1'b1; c_dev[0] = 8'h56; c_addr[0] = 16'h1234; c_data[0] = 8'hA5;
      fire(3'b001, acyc);
      vec++; if (req_busy !== 3'b001) begin err++;
         $display("FAIL single_busy_set: req_busy=%b, required 001", req_busy); end
      wait_pluse(1, 50, ok);
      vec++; if (!ok) begin err++; $display("FAIL single_pluse: no m_pluse, required one"); end
      if (ok) begin
         vec++; if (pl_q[0].cyc != acyc + 3) begin err++;
            $display("FAIL single_latency: pluse at %0d, required %0d", pl_q[0].cyc, acyc + 3); end
         vec++; if ({pl_q[0].w, pl_q[0].dev, pl_q[0].addr, pl_q[0].data} !== {1'b1, 8'h56, 16'h1234, 8'hA5}) begin err++;
            $display("FAIL single_fields: w=%b dev=%h addr=%h data=%h, required 1 56 1234 a5",
                     pl_q[0].w, pl_q[0].dev, pl_q[0].addr, pl_q[0].data); end
      end
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin @(negedge sys_clk); if (m_busy) begin ok = 1'b1; break; end end
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin @(negedge sys_clk); if (!m_busy) begin ok = 1'b1; break; end end
      vec++; if (!ok) begin err++; $display("FAIL single_busy_cycle: m_busy never fell, required fall"); end
      if (ok) begin
         vec++; if (req_busy[0] !== 1'b1) begin err++;
            $display("FAIL single_busy_hold: req_busy[0]=%b when m_busy fell, required 1", req_busy[0]); end
         repeat (2) @(negedge sys_clk);
         vec++; if (req_busy[0] !== 1'b0) begin err++;
            $display("FAIL single_busy_clear: req_busy[0]=%b, required 0", req_busy[0]); end
      end
      wait_idle(20, ok);
      vec++; if (pl_q.size() != 1 || b2b != 0) begin err++;
         $display("FAIL single_count: pluses=%0d wide=%0d, required 1 and 0", pl_q.size(), b2b); end
   endtask

   task automatic test_simultaneous();
      int acyc; bit ok;
      do_reset();
      pl_q.delete(); b2b = 0;
      c_w[0] = 1'b1; c_dev[0] = 8'h20; c_addr[0] = 16'h0A0A; c_data[0] = 8'h11;
      c_w[1] = 1'b1; c_dev[1] = 8'h22; c_addr[1] = 16'h0B0B; c_data[1] = 8'h22;
      fire(3'b011, acyc);
      vec++; if (req_busy !== 3'b011) begin err++;
         $display("FAIL simul_capture: req_busy=%b, required 011", req_busy); end
      wait_idle(200, ok);
      vec++; if (!ok || pl_q.size() != 2) begin err++;
         $display("FAIL simul_count: idle=%0d pluses=%0d, required 1 and 2", ok, pl_q.size()); end
      else begin
         vec++; if (pl_q[0].addr !== 16'h0A0A || pl_q[1].addr !== 16'h0B0B) begin err++;
            $display("FAIL simul_order: first=%h second=%h, required 0a0a then 0b0b", pl_q[0].addr, pl_q[1].addr); end
         vec++; if (b2b != 0 || pl_q[1].cyc - pl_q[0].cyc < 3) begin err++;
            $display("FAIL simul_gap: gap=%0d wide=%0d, required gap>=3 and 0", pl_q[1].cyc - pl_q[0].cyc, b2b); end
      end
   endtask

   task automatic test_read();
      int acyc; bit ok;
      pl_q.delete(); bo_q.delete();
      c_w[1] = 1'b0; c_dev[1] = 8'h57; c_addr[1] = 16'h0066; c_data[1] = 8'h00;
      fire(3'b010, acyc);
      wait_idle(100, ok);
      vec++; if (!ok || bo_q.size() != 1) begin err++;
         $display("FAIL read_events: idle=%0d byte_over events=%0d, required 1 and 1", ok, bo_q.size()); end
      else begin
         vec++; if (bo_q[0].mask !== 3'b010 || bo_q[0].data !== 8'h3C) begin err++;
            $display("FAIL read_data: mask=%b data=%h, required 010 3c", bo_q[0].mask, bo_q[0].data); end
      end
      vec++; if (req_data_out !== 8'h3C) begin err++;
         $display("FAIL read_hold: req_data_out=%h, required 3c", req_data_out); end
   endtask

   task automatic test_stray_byte_over();
      @(posedge sys_clk); #1 stray_bo = 1'b1;
      @(negedge sys_clk);
      vec++; if (req_byte_over !== '0 || req_data_out !== 8'h3C) begin err++;
         $display("FAIL stray_fwd: byte_over=%b data_out=%h, required 000 3c", req_byte_over, req_data_out); end
      @(posedge sys_clk); #1 stray_bo = 1'b0;
      @(negedge sys_clk);
      vec++; if (req_data_out !== 8'h3C) begin err++;
         $display("FAIL stray_capture: req_data_out=%h, required 3c", req_data_out); end
   endtask

   task automatic test_proto_err();
      int acyc; bit ok;
      pl_q.delete();
      c_w[0] = 1'b1; c_dev[0] = 8'h56; c_addr[0] = 16'h1111; c_data[0] = 8'h5A;
      fire(3'b001, acyc);
      wait_pluse(1, 50, ok);
      vec++; if (proto_err !== 1'b0) begin err++;
         $display("FAIL proto_pre: proto_err=%b, required 0", proto_err); end
      c_addr[0] = 16'hFFFF;
      fire(3'b001, acyc);
      @(negedge sys_clk);
      vec++; if (proto_err !== 1'b1 || m_addr !== 16'h1111) begin err++;
         $display("FAIL proto_set: proto_err=%b m_addr=%h, required 1 1111", proto_err, m_addr); end
      wait_idle(100, ok);
      vec++; if (!ok || pl_q.size() != 1) begin err++;
         $display("FAIL proto_drop: idle=%0d pluses=%0d, required 1 and 1", ok, pl_q.size()); end
   endtask

   task automatic test_timeout();
      int acyc, p; bit ok;
      do_reset();
      pl_q.delete(); bo_q.delete();
      dri_mute = 1'b1;
      c_w[0] = 1'b1; c_dev[0] = 8'h40; c_addr[0] = 16'h0001; c_data[0] = 8'h01;
      c_w[1] = 1'b0; c_dev[1] = 8'h41; c_addr[1] = 16'h0002; c_data[1] = 8'h02;
      fire(3'b001, acyc);
      wait_pluse(1, 50, ok);
      p = ok ? pl_q[0].cyc : cyc;
      fire(3'b010, acyc);
      while (cyc < p + T - 1) @(negedge sys_clk);
      vec++; if (tmo_err !== 1'b0 || req_busy[0] !== 1'b1) begin err++;
         $display("FAIL tmo_early: tmo_err=%b req_busy0=%b, required 0 1", tmo_err, req_busy[0]); end
      while (cyc < p + T + 2) @(negedge sys_clk);
      vec++; if (tmo_err !== 1'b1) begin err++;
         $display("FAIL tmo_set: tmo_err=%b, required 1", tmo_err); end
      dri_mute = 1'b0;
      @(negedge sys_clk);
      vec++; if (req_busy[0] !== 1'b0 || req_busy[1] !== 1'b1) begin err++;
         $display("FAIL tmo_release: req_busy=%b, required bit0=0 bit1=1", req_busy); end
      wait_idle(200, ok);
      vec++; if (!ok || pl_q.size() != 2 || bo_q.size() != 1) begin err++;
         $display("FAIL tmo_next: idle=%0d pluses=%0d events=%0d, required 1 2 1", ok, pl_q.size(), bo_q.size()); end
      else begin
         vec++; if (pl_q[1].addr !== 16'h0002 || bo_q[0].mask !== 3'b010) begin err++;
            $display("FAIL tmo_next_fields: addr=%h mask=%b, required 0002 010", pl_q[1].addr, bo_q[0].mask); end
      end
   endtask

   task automatic test_reset_mid();
      int acyc; bit ok;
      do_reset();
      pl_q.delete();
      c_w[0] = 1'b1; c_dev[0] = 8'h30; c_addr[0] = 16'h3333; c_data[0] = 8'h33;
      c_w[1] = 1'b1; c_dev[1] = 8'h31; c_addr[1] = 16'h4444; c_data[1] = 8'h44;
      fire(3'b011, acyc);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin @(negedge sys_clk); if (m_busy) begin ok = 1'b1; break; end end
      repeat (5) @(negedge sys_clk);
      sys_rst = 1'b1;
      #1;
      vec++; if (req_busy !== '0 || m_pluse !== 1'b0 || req_byte_over !== '0) begin err++;
         $display("FAIL midrst_clear: busy=%b pluse=%b byte_over=%b, required 0", req_busy, m_pluse, req_byte_over); end
      vec++; if (m_addr !== 16'h0 || tmo_err !== 1'b0 || proto_err !== 1'b0) begin err++;
         $display("FAIL midrst_out: m_addr=%h tmo=%b proto=%b, required 0", m_addr, tmo_err, proto_err); end
      repeat (2) @(posedge sys_clk);
      #1 sys_rst = 1'b0;
      pl_q.delete();
      c_addr[1] = 16'h5555;
      fire(3'b010, acyc);
      wait_idle(100, ok);
      vec++; if (!ok || pl_q.size() != 1) begin err++;
         $display("FAIL midrst_after: idle=%0d pluses=%0d, required 1 and 1", ok, pl_q.size()); end
      else begin
         vec++; if (pl_q[0].addr !== 16'h5555 || pl_q[0].cyc != acyc + 3) begin err++;
            $display("FAIL midrst_frame: addr=%h at %0d, required 5555 at %0d", pl_q[0].addr, pl_q[0].cyc, acyc + 3); end
      end
   endtask

   task automatic test_random();
      int acyc, last, first, nxt;
      logic [N-1:0] a, b, rest;
      int order[$];
      bit ok;
      do_reset();
      last = N - 1;
      b2b = 0;
      for (int r = 0; r < 12; r++) begin
         pl_q.delete(); bo_q.delete(); order.delete();
         a = N'($urandom_range(1, (1 << N) - 1));
         rand_cmds(a);
         fire(a, acyc);
         first = rr_next(a, last);
         order.push_back(first);
         wait_pluse(1, 50, ok);
         repeat (10) @(negedge sys_clk);
         b = N'($urandom_range(0, (1 << N) - 1)) & ~a;
         if (b != '0) begin rand_cmds(b); fire(b, acyc); end
         rest = (a | b);
         rest[first] = 1'b0;
         last = first;
         while (rest != '0) begin
            nxt = rr_next(rest, last);
            order.push_back(nxt);
            rest[nxt] = 1'b0;
            last = nxt;
         end
         wait_idle(400, ok);
         vec++; if (!ok || pl_q.size() != order.size() || bo_q.size() != order.size()) begin err++;
            $display("FAIL rand_count r%0d: idle=%0d pluses=%0d events=%0d, required %0d", r, ok,
                     pl_q.size(), bo_q.size(), order.size()); end
         else begin
            for (int j = 0; j < order.size(); j++) begin
               vec++; if ({pl_q[j].w, pl_q[j].dev, pl_q[j].addr, pl_q[j].data} !==
                          {c_w[order[j]], c_dev[order[j]], c_addr[order[j]], c_data[order[j]]}) begin err++;
                  $display("FAIL rand_cmd r%0d #%0d: addr=%h dev=%h, required req%0d addr=%h dev=%h", r, j,
                           pl_q[j].addr, pl_q[j].dev, order[j], c_addr[order[j]], c_dev[order[j]]); end
               vec++; if (bo_q[j].mask !== N'(1 << order[j]) || bo_q[j].data !== (c_addr[order[j]][7:0] ^ 8'h5A)) begin err++;
                  $display("FAIL rand_ret r%0d #%0d: mask=%b data=%h, required req%0d data=%h", r, j,
                           bo_q[j].mask, bo_q[j].data, order[j], c_addr[order[j]][7:0] ^ 8'h5A); end
            end
         end
      end
      vec++; if (proto_err !== 1'b0 || tmo_err !== 1'b0 || b2b != 0) begin err++;
         $display("FAIL rand_flags: proto=%b tmo=%b wide=%0d, required 0 0 0", proto_err, tmo_err, b2b); end
   endtask

   initial begin
      sys_rst = 1'b1; req_trig = '0; req_w_r = '0; req_device_id = '0; req_addr = '0;
      req_data_in = '0; stray_bo = 1'b0; dri_mute = 1'b0;
      test_reset();
      test_single_write();
      test_simultaneous();
      test_read();
      test_stray_byte_over();
      test_proto_err();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
